id_pair_packer: RTL

Downstream stage of the accelerator's ID-pair output stream. Accepts one (reference ID, compared ID) pair per beat from the pipeline's M_AXIS_ID_PAIR master and packs consecutive pairs into BUS_WIDTH-bit words for the DMA write stream. A partial word is flushed on `tlast` with a byte-accurate `tkeep`. A single output register decouples DMA back-pressure from the pipeline.

---
 rtl/id_pair_packer_if.sv | 23 ++
 rtl/id_pair_packer.sv | 66 ++++++
 2 files changed

// File: rtl/id_pair_packer_if.sv
// id_pair_packer_if: ID-pair input stream and packed-word output stream.
interface id_pair_packer_if #(
    parameter int BUS_WIDTH  = 512,
    parameter int PAIR_WIDTH = 16
);
    logic [PAIR_WIDTH-1:0]  S_AXIS_ID_PAIR_tdata;
    logic                   S_AXIS_ID_PAIR_tvalid;
    logic                   S_AXIS_ID_PAIR_tlast;
    logic                   S_AXIS_ID_PAIR_tready;
    logic [BUS_WIDTH-1:0]   M_AXIS_DATA_tdata;
    logic [BUS_WIDTH/8-1:0] M_AXIS_DATA_tkeep;
    logic                   M_AXIS_DATA_tvalid;
    logic                   M_AXIS_DATA_tlast;
    logic                   M_AXIS_DATA_tready;
    modport master (
        output S_AXIS_ID_PAIR_tdata, S_AXIS_ID_PAIR_tvalid, S_AXIS_ID_PAIR_tlast, M_AXIS_DATA_tready,
        input  S_AXIS_ID_PAIR_tready, M_AXIS_DATA_tdata, M_AXIS_DATA_tkeep, M_AXIS_DATA_tvalid, M_AXIS_DATA_tlast
    );
    modport slave (
        input  S_AXIS_ID_PAIR_tdata, S_AXIS_ID_PAIR_tvalid, S_AXIS_ID_PAIR_tlast, M_AXIS_DATA_tready,
        output S_AXIS_ID_PAIR_tready, M_AXIS_DATA_tdata, M_AXIS_DATA_tkeep, M_AXIS_DATA_tvalid, M_AXIS_DATA_tlast
    );
endinterface

// File: rtl/id_pair_packer.sv
// id_pair_packer: packs ID pairs into bus-width words, flushing partial words on tlast.
module id_pair_packer #(
    parameter int BUS_WIDTH      = 512,
    parameter int VEC_ID_WIDTH   = 8,
    parameter int PAIR_WIDTH     = 2*VEC_ID_WIDTH,
    parameter int PAIRS_PER_WORD = BUS_WIDTH/PAIR_WIDTH,
    parameter int SLOT_WIDTH     = $clog2(PAIRS_PER_WORD)
)(
    input  logic                ap_clk,
    input  logic                ap_rst,
    id_pair_packer_if.slave     bus,
    output logic [31:0]         o_PairCount,
    output logic                o_Busy
);
    localparam int KEEP_WIDTH = BUS_WIDTH/8;
    localparam int PAIR_BYTES = PAIR_WIDTH/8;
    localparam logic [SLOT_WIDTH-1:0] LAST_SLOT = SLOT_WIDTH'(PAIRS_PER_WORD-1);
    localparam logic [KEEP_WIDTH-1:0] KEEP_ONES = '1;
    logic [BUS_WIDTH-1:0]  asm_q, asm_d, merged, data_q, data_d;
    logic [KEEP_WIDTH-1:0] keep_q, keep_d;
    logic [SLOT_WIDTH-1:0] slot_q, slot_d;
    logic [31:0]           count_q, count_d;
    logic                  valid_q, valid_d, last_q, last_d;
    logic                  accept, flush, drain;
    assign bus.S_AXIS_ID_PAIR_tready = !valid_q || bus.M_AXIS_DATA_tready;
    assign bus.M_AXIS_DATA_tdata     = data_q;
    assign bus.M_AXIS_DATA_tkeep     = keep_q;
    assign bus.M_AXIS_DATA_tvalid    = valid_q;
    assign bus.M_AXIS_DATA_tlast     = last_q;
    assign o_PairCount               = count_q;
    assign o_Busy                    = (slot_q != '0) || valid_q;
    always_comb begin
        accept = bus.S_AXIS_ID_PAIR_tvalid && bus.S_AXIS_ID_PAIR_tready;
        flush  = accept && (slot_q == LAST_SLOT || bus.S_AXIS_ID_PAIR_tlast);
        drain  = valid_q && bus.M_AXIS_DATA_tready;
        // slots above the current one are already zero since asm clears on every flush
        merged = asm_q;
        merged[int'(slot_q)*PAIR_WIDTH +: PAIR_WIDTH] = bus.S_AXIS_ID_PAIR_tdata;
        slot_d  = flush ? '0 : accept ? slot_q + SLOT_WIDTH'(1) : slot_q;
        asm_d   = flush ? '0 : accept ? merged : asm_q;
        valid_d = flush || (valid_q && !drain);
        data_d  = flush ? merged : data_q;
        keep_d  = flush ? ~(KEEP_ONES << ((int'(slot_q) + 1) * PAIR_BYTES)) : keep_q;
        last_d  = flush ? bus.S_AXIS_ID_PAIR_tlast : last_q;
        count_d = count_q + 32'(accept);
    end
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            asm_q   <= '0;
            slot_q  <= '0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            asm_q   <= asm_d;
            slot_q  <= slot_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end
endmodule
